// File: rtl/vram_arbiter.sv
// Arbitrates one memory controller between the VDP slot port, a level-handshake
// secondary port and periodic refresh, issuing one command at a time.
module vram_arbiter #(
    parameter int REFRESH_INTERVAL = 210,
    parameter int MAX_CREDIT       = 3
) (
    input  logic        clk_w,
    input  logic        reset_n_w,
    input  logic        mc_enabled,
    input  logic        vdp_req,
    input  logic        vdp_we_n,
    input  logic [16:0] vdp_addr,
    input  logic [7:0]  vdp_wdata,
    output logic [15:0] vdp_rdata,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [21:0] ext_addr,
    input  logic [15:0] ext_wdata,
    input  logic [1:0]  ext_wdm,
    output logic        ext_ack,
    output logic [15:0] ext_rdata,
    output logic        mc_read,
    output logic        mc_write,
    output logic        mc_refresh,
    output logic [21:0] mc_addr,
    output logic [15:0] mc_din,
    output logic [1:0]  mc_wdm,
    input  logic        mc_busy,
    input  logic [15:0] mc_dout,
    output logic        refresh_overrun
);

    // state     | meaning
    // IDLE      | pick the next requester (VDP > refresh>=2 > ext > refresh==1)
    // ISSUE     | one-cycle command strobe on the mc_* bus
    // WAIT_BUSY | wait for the controller to go busy, give up after 4 cycles
    // WAIT_DONE | wait for busy to drop, then complete the granted access
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    typedef enum logic [1:0] {GNT_VDP, GNT_REF, GNT_EXT} grant_t;

    localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int CRD_W = $clog2(MAX_CREDIT + 1);

    state_t             state_q, state_d;
    grant_t             grant_q, grant_d;
    logic               vdp_pending_q, vdp_pending_d;
    logic               vdp_we_n_q, vdp_we_n_d;
    logic [16:0]        vdp_addr_q, vdp_addr_d;
    logic [7:0]         vdp_wdata_q, vdp_wdata_d;
    logic               op_read_q, op_read_d;
    logic [1:0]         wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [CRD_W-1:0]   credit_q, credit_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        vdp_rdata_q, vdp_rdata_d;
    logic [15:0]        ext_rdata_q, ext_rdata_d;
    logic               ext_ack_q, ext_ack_d;
    logic               mc_read_q, mc_read_d;
    logic               mc_write_q, mc_write_d;
    logic               mc_refresh_q, mc_refresh_d;
    logic [21:0]        mc_addr_q, mc_addr_d;
    logic [15:0]        mc_din_q, mc_din_d;
    logic [1:0]         mc_wdm_q, mc_wdm_d;
    logic               ref_wrap, complete, credit_dec;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        vdp_pending_d = vdp_pending_q;
        vdp_we_n_d    = vdp_we_n_q;
        vdp_addr_d    = vdp_addr_q;
        vdp_wdata_d   = vdp_wdata_q;
        op_read_d     = op_read_q;
        wait_cnt_d    = wait_cnt_q;
        credit_d      = credit_q;
        overrun_d     = overrun_q;
        vdp_rdata_d   = vdp_rdata_q;
        ext_rdata_d   = ext_rdata_q;
        ext_ack_d     = 1'b0;
        mc_read_d     = 1'b0;
        mc_write_d    = 1'b0;
        mc_refresh_d  = 1'b0;
        mc_addr_d     = mc_addr_q;
        mc_din_d      = mc_din_q;
        mc_wdm_d      = mc_wdm_q;
        complete      = 1'b0;
        credit_dec    = 1'b0;

        if (vdp_req) begin
            vdp_pending_d = 1'b1;
            vdp_we_n_d    = vdp_we_n;
            vdp_addr_d    = vdp_addr;
            vdp_wdata_d   = vdp_wdata;
        end

        ref_wrap  = (ref_cnt_q == CNT_W'(REFRESH_INTERVAL - 1));
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                // A strobe arriving this cycle counts as pending so it wins a tie with ext_req.
                if (mc_enabled && !mc_busy) begin
                    if (vdp_pending_d) begin
                        grant_d    = GNT_VDP;
                        op_read_d  = vdp_we_n_d;
                        mc_read_d  = vdp_we_n_d;
                        mc_write_d = !vdp_we_n_d;
                        mc_addr_d  = {6'b0, vdp_addr_d[15:0]};
                        mc_din_d   = {vdp_wdata_d, vdp_wdata_d};
                        mc_wdm_d   = vdp_we_n_d ? 2'b00 : {~vdp_addr_d[16], vdp_addr_d[16]};
                        state_d    = ISSUE;
                    end else if (credit_q > CRD_W'(1)) begin
                        grant_d      = GNT_REF;
                        mc_refresh_d = 1'b1;
                        state_d      = ISSUE;
                    end else if (ext_req && !ext_ack_q) begin
                        grant_d    = GNT_EXT;
                        op_read_d  = !ext_we;
                        mc_read_d  = !ext_we;
                        mc_write_d = ext_we;
                        mc_addr_d  = ext_addr;
                        mc_din_d   = ext_wdata;
                        mc_wdm_d   = ext_wdm;
                        state_d    = ISSUE;
                    end else if (credit_q == CRD_W'(1)) begin
                        grant_d      = GNT_REF;
                        mc_refresh_d = 1'b1;
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wait_cnt_d = 2'd3;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (mc_busy) begin
                    state_d = WAIT_DONE;
                end else if (wait_cnt_q == 2'd0) begin
                    complete = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!mc_busy) begin
                    complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            state_d = IDLE;
            case (grant_q)
                GNT_VDP: begin
                    if (op_read_q) begin
                        vdp_rdata_d = mc_dout;
                    end
                    if (!vdp_req) begin
                        vdp_pending_d = 1'b0;
                    end
                end
                GNT_EXT: begin
                    ext_ack_d = 1'b1;
                    if (op_read_q) begin
                        ext_rdata_d = mc_dout;
                    end
                end
                GNT_REF: credit_dec = 1'b1;
                default: ;
            endcase
        end

        // Simultaneous earn and spend cancel out.
        if (ref_wrap && !credit_dec) begin
            if (credit_q == CRD_W'(MAX_CREDIT)) begin
                overrun_d = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end else if (!ref_wrap && credit_dec && credit_q != '0) begin
            credit_d = credit_q - 1'b1;
        end
    end

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            state_q       <= IDLE;
            grant_q       <= GNT_VDP;
            vdp_pending_q <= 1'b0;
            vdp_we_n_q    <= 1'b1;
            vdp_addr_q    <= '0;
            vdp_wdata_q   <= '0;
            op_read_q     <= 1'b0;
            wait_cnt_q    <= '0;
            ref_cnt_q     <= '0;
            credit_q      <= '0;
            overrun_q     <= 1'b0;
            vdp_rdata_q   <= '0;
            ext_rdata_q   <= '0;
            ext_ack_q     <= 1'b0;
            mc_read_q     <= 1'b0;
            mc_write_q    <= 1'b0;
            mc_refresh_q  <= 1'b0;
            mc_addr_q     <= '0;
            mc_din_q      <= '0;
            mc_wdm_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            vdp_pending_q <= vdp_pending_d;
            vdp_we_n_q    <= vdp_we_n_d;
            vdp_addr_q    <= vdp_addr_d;
            vdp_wdata_q   <= vdp_wdata_d;
            op_read_q     <= op_read_d;
            wait_cnt_q    <= wait_cnt_d;
            ref_cnt_q     <= ref_cnt_d;
            credit_q      <= credit_d;
            overrun_q     <= overrun_d;
            vdp_rdata_q   <= vdp_rdata_d;
            ext_rdata_q   <= ext_rdata_d;
            ext_ack_q     <= ext_ack_d;
            mc_read_q     <= mc_read_d;
            mc_write_q    <= mc_write_d;
            mc_refresh_q  <= mc_refresh_d;
            mc_addr_q     <= mc_addr_d;
            mc_din_q      <= mc_din_d;
            mc_wdm_q      <= mc_wdm_d;
        end
    end

    assign vdp_rdata       = vdp_rdata_q;
    assign ext_rdata       = ext_rdata_q;
    assign ext_ack         = ext_ack_q;
    assign mc_read         = mc_read_q;
    assign mc_write        = mc_write_q;
    assign mc_refresh      = mc_refresh_q;
    assign mc_addr         = mc_addr_q;
    assign mc_din          = mc_din_q;
    assign mc_wdm          = mc_wdm_q;
    assign refresh_overrun = overrun_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a small memory-controller responder plus a
// command log, with hand-computed expectations checked by immediate assertions.
module tb_vram_arbiter;

    logic        clk_w = 1'b0;
    logic        reset_n_w = 1'b0;
    logic        mc_enabled = 1'b0;
    logic        vdp_req = 1'b0;
    logic        vdp_we_n = 1'b1;
    logic [16:0] vdp_addr = '0;
    logic [7:0]  vdp_wdata = '0;
    logic [15:0] vdp_rdata;
    logic        ext_req = 1'b0;
    logic        ext_we = 1'b0;
    logic [21:0] ext_addr = '0;
    logic [15:0] ext_wdata = '0;
    logic [1:0]  ext_wdm = '0;
    logic        ext_ack;
    logic [15:0] ext_rdata;
    logic        mc_read, mc_write, mc_refresh;
    logic [21:0] mc_addr;
    logic [15:0] mc_din;
    logic [1:0]  mc_wdm;
    logic        mc_busy = 1'b0;
    logic [15:0] mc_dout = '0;
    logic        refresh_overrun;

    int n_chk = 0;
    int n_pass = 0;

    // responder control (written by the stimulus only)
    int          resp_mode = 0;     // 0: busy stuck low, 1: busy pulse after strobe, 2: busy stuck high
    int          busy_len = 3;
    logic [15:0] dout_base = '0;
    int          busy_left = 0;

    // command log (written by the monitor only)
    logic [1:0]  log_kind [256];
    logic [21:0] log_addr [256];
    logic [15:0] log_din  [256];
    logic [1:0]  log_wdm  [256];
    int log_n = 0, n_read = 0, n_write = 0, n_refresh = 0, n_ack = 0, n_multi = 0;

    vram_arbiter #(.REFRESH_INTERVAL(8), .MAX_CREDIT(3)) dut (
        .clk_w(clk_w), .reset_n_w(reset_n_w), .mc_enabled(mc_enabled),
        .vdp_req(vdp_req), .vdp_we_n(vdp_we_n), .vdp_addr(vdp_addr),
        .vdp_wdata(vdp_wdata), .vdp_rdata(vdp_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_wdm(ext_wdm), .ext_ack(ext_ack),
        .ext_rdata(ext_rdata), .mc_read(mc_read), .mc_write(mc_write),
        .mc_refresh(mc_refresh), .mc_addr(mc_addr), .mc_din(mc_din),
        .mc_wdm(mc_wdm), .mc_busy(mc_busy), .mc_dout(mc_dout),
        .refresh_overrun(refresh_overrun)
    );

    always #5 clk_w = ~clk_w;

    always @(negedge clk_w) begin
        if (mc_read || mc_write || mc_refresh) begin
            mc_dout = dout_base ^ mc_addr[15:0];
        end
        if (resp_mode == 0) begin
            busy_left = 0;
            mc_busy   = 1'b0;
        end else if (resp_mode == 2) begin
            busy_left = 0;
            mc_busy   = 1'b1;
        end else begin
            if (mc_read || mc_write || mc_refresh) busy_left = busy_len;
            else if (busy_left > 0) busy_left = busy_left - 1;
            mc_busy = (busy_left > 0);
        end
    end

    always @(negedge clk_w) begin
        if (int'(mc_read) + int'(mc_write) + int'(mc_refresh) > 1) n_multi = n_multi + 1;
        if (mc_read)    n_read = n_read + 1;
        if (mc_write)   n_write = n_write + 1;
        if (mc_refresh) n_refresh = n_refresh + 1;
        if (ext_ack)    n_ack = n_ack + 1;
        if ((mc_read || mc_write || mc_refresh) && log_n < 256) begin
            log_kind[log_n] = mc_refresh ? 2'd3 : (mc_write ? 2'd2 : 2'd1);
            log_addr[log_n] = mc_addr;
            log_din[log_n]  = mc_din;
            log_wdm[log_n]  = mc_wdm;
            log_n = log_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_w);
        #1;
    endtask

    task automatic do_reset();
        reset_n_w = 1'b0;
        cycles(2);
        reset_n_w = 1'b1;
    endtask

    task automatic vdp_pulse(input logic we_n, input logic [16:0] a, input logic [7:0] d);
        vdp_req = 1'b1; vdp_we_n = we_n; vdp_addr = a; vdp_wdata = d;
        cycles(1);
        vdp_req = 1'b0;
    endtask

    task automatic wait_ack(input int max_cyc, output bit ok, output logic [15:0] rd);
        ok = 1'b0;
        rd = '0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            cycles(1);
            if (ext_ack) begin
                ok = 1'b1;
                rd = ext_rdata;
            end
        end
    endtask

    initial begin
        int s, a0, wi, idx;
        bit ok;
        logic [15:0] rd;

        // reset values
        #1;
        chk("rst_strobes", {29'b0, mc_read, mc_write, mc_refresh}, 0);
        chk("rst_ack", ext_ack, 0);
        chk("rst_overrun", refresh_overrun, 0);
        chk("rst_mc_bus", {mc_addr, mc_din, mc_wdm} != 0, 0);
        chk("rst_rdata", {vdp_rdata, ext_rdata}, 0);
        mc_enabled = 1'b1;

        // VDP write, busy 3 cycles
        resp_mode = 1; busy_len = 3;
        do_reset();
        s = log_n; a0 = n_write;
        vdp_pulse(1'b0, 17'h10123, 8'hA5);
        cycles(16);
        chk("vdp_wr_count", n_write - a0, 1);
        chk("vdp_wr_first_kind", log_kind[s], 2);
        chk("vdp_wr_addr", log_addr[s], 22'h000123);
        chk("vdp_wr_din", log_din[s], 16'hA5A5);
        chk("vdp_wr_wdm", log_wdm[s], 2'b01);
        chk("vdp_wr_addr_hold", mc_addr, 22'h000123);

        // VDP and ext requested together: VDP first, ext once
        busy_len = 2; dout_base = 16'hBEEF;
        do_reset();
        s = log_n; a0 = n_ack;
        ext_we = 1'b0; ext_addr = 22'h3ABCDE; ext_req = 1'b1;
        vdp_pulse(1'b1, 17'h00456, 8'h00);
        wait_ack(40, ok, rd);
        ext_req = 1'b0;
        chk("tie_ack_seen", ok, 1);
        chk("tie_ext_rdata", rd, 16'h0231);
        chk("tie_first_addr", log_addr[s], 22'h000456);
        chk("tie_second_addr", log_addr[s+1], 22'h3ABCDE);
        chk("tie_both_reads", {log_kind[s], log_kind[s+1]}, 4'b0101);
        cycles(20);
        chk("tie_ack_once", n_ack - a0, 1);
        chk("tie_vdp_rdata", vdp_rdata, 16'hBAB9);

        // mc_enabled low blocks grants; raising it lets the held VDP read go
        dout_base = 16'h1234;
        mc_enabled = 1'b0;
        do_reset();
        s = log_n;
        vdp_pulse(1'b1, 17'h00000, 8'h00);
        cycles(12);
        chk("dis_no_cmd", log_n - s, 0);
        mc_enabled = 1'b1;
        cycles(12);
        chk("en_first_kind", log_kind[s], 1);
        chk("en_first_addr", log_addr[s], 22'h0);
        chk("en_vdp_rdata", vdp_rdata, 16'h1234);

        // reset while an ext read sits in WAIT_DONE
        busy_len = 10; dout_base = 16'h0F0F;
        do_reset();
        a0 = n_ack; s = n_read;
        ext_we = 1'b0; ext_addr = 22'h000321; ext_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            cycles(1);
            if (mc_read) ok = 1'b1;
        end
        chk("rw_strobe_seen", ok, 1);
        cycles(2);
        reset_n_w = 1'b0; resp_mode = 0;
        #1;
        chk("rw_ack_low", ext_ack, 0);
        chk("rw_strobes_low", {mc_read, mc_write, mc_refresh}, 0);
        chk("rw_mc_addr", mc_addr, 0);
        chk("rw_mc_din_wdm", {mc_din, mc_wdm}, 0);
        chk("rw_rdata", {vdp_rdata, ext_rdata}, 0);
        cycles(2);
        reset_n_w = 1'b1; resp_mode = 1; busy_len = 2;
        chk("rw_no_ack_dropped", n_ack - a0, 0);
        wait_ack(30, ok, rd);
        ext_req = 1'b0;
        chk("rw_regrant_ack", ok, 1);
        chk("rw_regrant_rdata", rd, 16'h0F0F ^ 16'h0321);
        chk("rw_two_reads", n_read - s, 2);

        // busy stuck high: credit saturates and overruns, refresh beats ext after release
        resp_mode = 2;
        ext_we = 1'b1; ext_addr = 22'h000777; ext_wdata = 16'h5555; ext_wdm = 2'b10;
        ext_req = 1'b1;
        do_reset();
        s = log_n;
        cycles(40);
        chk("sat_no_cmd", log_n - s, 0);
        chk("sat_overrun", refresh_overrun, 1);
        resp_mode = 1; busy_len = 2;
        wait_ack(80, ok, rd);
        ext_req = 1'b0;
        chk("sat_ext_ack", ok, 1);
        chk("sat_first_refresh", log_kind[s], 3);
        wi = -1;
        for (int i = s; i < log_n; i++) if (log_kind[i] == 2'd2 && wi < 0) wi = i;
        idx = (wi < 0) ? s : wi;
        chk("sat_ext_found", wi >= s + 1, 1);
        chk("sat_ext_map", {log_addr[idx], log_din[idx], log_wdm[idx]}, {22'h000777, 16'h5555, 2'b10});
        chk("sat_overrun_sticky", refresh_overrun, 1);

        // ext held, busy stuck low: refresh interleaves without overrun
        resp_mode = 0;
        ext_we = 1'b0; ext_addr = 22'h000100; ext_req = 1'b1;
        do_reset();
        s = n_refresh; a0 = n_ack;
        cycles(120);
        ext_req = 1'b0;
        chk("il_refreshes", (n_refresh - s) >= 3, 1);
        chk("il_acks", (n_ack - a0) >= 5, 1);
        chk("il_no_overrun", refresh_overrun, 0);
        cycles(10);
        chk("one_strobe_at_a_time", n_multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 210, clk_w cycles between refresh credits (7.8 us at 27 MHz).
REQ-002 SHALL have parameter MAX_CREDIT, default 3, saturation limit of the refresh credit counter.
REQ-003 clk_w  input  1  pixel/CPU clock; all logic on rising edge.
REQ-004 reset_n_w  input  1  asynchronous, active-low reset.
REQ-005 mc_enabled  input  1  memory controller initialised; no commands issued while low.
REQ-006 vdp_req  input  1  one-cycle VDP access request (VDP slot strobe).
REQ-007 vdp_we_n  input  1  0 = write, 1 = read; sampled with vdp_req.
REQ-008 vdp_addr  input  17  VDP byte address; sampled with vdp_req.
REQ-009 vdp_wdata  input  8  VDP write byte; sampled with vdp_req.
REQ-010 vdp_rdata  output  16  last VDP read word.
REQ-011 ext_req  input  1  level request from secondary port; held until ext_ack.
REQ-012 ext_we  input  1  1 = write.
REQ-013 ext_addr  input  22  word address.
REQ-014 ext_wdata  input  16  write word.
REQ-015 ext_wdm  input  2  byte masks, 1 = byte masked.
REQ-016 ext_ack  output  1  one-cycle completion pulse; ext_rdata valid same cycle.
REQ-017 ext_rdata  output  16  read word.
REQ-018 mc_read, mc_write, mc_refresh  output  1 each  one-cycle command strobes.
REQ-019 mc_addr  output  22; mc_din  output  16; mc_wdm  output  2.
REQ-020 mc_busy  input  1; mc_dout  input  16.
REQ-021 refresh_overrun  output  1  sticky; set when credit would exceed MAX_CREDIT.

Function
REQ-022 States SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-023 vdp_req SHALL set vdp_pending and latch we_n/addr/wdata in any state; a vdp_req arriving while vdp_pending=1 overwrites the latched request.
REQ-024 Refresh counter SHALL count 0..REFRESH_INTERVAL-1 and wrap; each wrap increments credit, saturating at MAX_CREDIT and setting refresh_overrun.
REQ-025 Priority in IDLE with mc_enabled=1 and mc_busy=0: vdp_pending > refresh (credit>=2) > ext_req > refresh (credit=1); choice registered as grant, transition to ISSUE.
REQ-026 ISSUE (1 cycle) SHALL assert exactly one strobe and drive mc_addr/mc_din/mc_wdm; go WAIT_BUSY.
REQ-027 VDP mapping: mc_addr = {6'b0, vdp_addr[15:0]}, mc_din = {wdata, wdata}, mc_wdm = {~vdp_addr[16], vdp_addr[16]} for writes, 2'b00 for reads.
REQ-028 Ext mapping: direct passthrough of ext_addr/ext_wdata/ext_wdm.
REQ-029 WAIT_BUSY: on mc_busy=1 go WAIT_DONE; if mc_busy stays 0 for 4 cycles, treat as done.
REQ-030 WAIT_DONE: on mc_busy=0 complete: VDP read -> vdp_rdata <= mc_dout, clear vdp_pending (unless re-set same cycle); ext -> ext_ack=1, ext_rdata <= mc_dout on reads; refresh -> credit decrements; return IDLE.
REQ-031 Credit increment and decrement in the same cycle SHALL leave credit unchanged.
REQ-032 mc_addr/mc_din/mc_wdm SHALL hold value outside ISSUE; strobes 0 outside ISSUE.
REQ-033 Minimum turnaround: completion to next ISSUE = 2 cycles (WAIT_DONE->IDLE->ISSUE).
REQ-034 mc_enabled falling SHALL not abort an access in flight; new grants blocked only in IDLE.

Reset
REQ-035 On reset_n_w=0: state IDLE, all strobes 0, ext_ack 0, vdp_pending 0, credit 0, refresh counter 0, refresh_overrun 0, vdp_rdata/ext_rdata/mc_addr/mc_din 0, mc_wdm 0.
REQ-036 Reset mid-access SHALL drop the access without ext_ack; ext_req still high after release is re-granted.

Verification
REQ-037 VDP write vdp_addr=17'h10123, wdata=8'hA5, busy 3 cycles -> one mc_write, mc_addr=22'h000123, mc_din=16'hA5A5, mc_wdm=2'b01.
REQ-038 vdp_req and ext_req same cycle, credit 0 -> VDP served first; ext served next; ext_ack exactly once.
REQ-039 ext_req held, mc_busy stuck 0, REFRESH_INTERVAL=8 -> refresh strobes interleave; credit never exceeds 1; refresh_overrun stays 0.
REQ-040 mc_busy held 1 for 40 cycles, REFRESH_INTERVAL=8 -> credit saturates at 3, refresh_overrun=1; after release refresh (credit>=2) granted before pending ext.
REQ-041 mc_enabled=0 with vdp_req pulse -> no strobe; mc_enabled=1 -> read issued, vdp_rdata=mc_dout (16'h1234).
REQ-042 Assert reset_n_w during WAIT_DONE of ext read -> all outputs reset values, no ext_ack; after release ext re-granted.
